// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI responder (spi_slave and spi_sync_edge).
// The optional build macro SPI_SLAVE_LSB_FIRST_EN is consumed by spi_slave.
package spi_slave_pkg;

  localparam int SPI_DATA_W = 32;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_t;

  // Bit-counter width; guarded so a degenerate width still yields a legal vector.
  function automatic int spi_cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for an asynchronous SPI pin.
// rise/fall are registered one-cycle pulses; level is the value that produced them.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= RESET_VAL;
      sync_2 <= RESET_VAL;
      sync_3 <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      rise   <= sync_2 & ~sync_3;
      fall   <= ~sync_2 & sync_3;
    end
  end

  assign level = sync_3;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/ss_n/mosi and exchanges one DATA_W-bit word per frame.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first framing in both directions (default MSB first).
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = spi_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t state, next_state;

  logic              sclk_level, sclk_rise, sclk_fall;
  logic              ss_level, ss_rise, ss_fall;
  logic              mosi_meta, mosi_sync;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, rx_next;
  logic [DATA_W-1:0] tx_shift, tx_next;
  logic [DATA_W-1:0] tx_hold, frame_word;
  logic              tx_pending;
  logic              frame_bit, shift_bit;
  logic              start, do_rise, do_fall, complete;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sclk),
    .level   (sclk_level),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ss_n),
    .level   (ss_level),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // An unloaded holding register sends zeros rather than repeating stale data.
  assign frame_word = tx_pending ? tx_hold : '0;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next   = (rx_shift >> 1) | {mosi_sync, {(DATA_W-1){1'b0}}};
  assign tx_next   = tx_shift >> 1;
  assign frame_bit = frame_word[0];
  assign shift_bit = tx_next[0];
`else
  assign rx_next   = (rx_shift << 1) | DATA_W'(mosi_sync);
  assign tx_next   = tx_shift << 1;
  assign frame_bit = frame_word[DATA_W-1];
  assign shift_bit = tx_next[DATA_W-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only an ss_n fall starts a frame, so sclk edges after completion are ignored.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    do_rise    = 1'b0;
    do_fall    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall && !ss_level) begin
          start      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          next_state = IDLE;
        end else if (sclk_rise && sclk_level) begin
          do_rise = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            complete   = 1'b1;
            next_state = IDLE;
          end
        end else if (sclk_fall && !sclk_level) begin
          do_fall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A load coinciding with a frame start is kept for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold    <= '0;
      tx_pending <= 1'b0;
    end else if (tx_load) begin
      tx_hold    <= tx_data;
      tx_pending <= 1'b1;
    end else if (start) begin
      tx_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      busy        <= (next_state == SHIFT);
      if (start) begin
        tx_shift    <= frame_word;
        miso        <= frame_bit;
        rx_shift    <= '0;
        bit_cnt     <= '0;
        tx_underrun <= ~tx_pending;
      end
      if (do_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (do_fall) begin
        tx_shift <= tx_next;
        miso     <= shift_bit;
      end
    end
  end

  // A completing word takes priority over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (complete) begin
        rx_data    <= rx_next;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ack;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: acts as a mode-0 SPI master at sclk = clk/8.
// Honours SPI_SLAVE_LSB_FIRST_EN for bit ordering.
module tb_spi_slave;

  logic        clk;
  logic        reset_n;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic [31:0] tx_data;
  logic        tx_load;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_overrun;
  logic        tx_underrun;
  logic        busy;

  int assertions_evaluated = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int udr_cnt = 0;

  spi_slave dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse flags are tallied away from the active edge.
  always @(negedge clk) begin
    if (rx_overrun)  ovr_cnt = ovr_cnt + 1;
    if (tx_underrun) udr_cnt = udr_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions_evaluated = assertions_evaluated + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w);
    tx_data = w;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic spi_bit(input logic b, input bit ack_here, output logic mi);
    mosi = b;
    wait_clk(4);
    mi = miso;
    sclk = 1'b1;
    wait_clk(3);
    if (ack_here) rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    sclk = 1'b0;
  endtask

  function automatic int bit_index(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return 31 - i;
`endif
  endfunction

  task automatic apply_stimulus(input logic [31:0] mw, input int nbits, input bit ack_last,
                                output logic [31:0] mi_word, output logic busy_mid);
    logic b;
    int   idx;
    mi_word  = '0;
    busy_mid = 1'b0;
    ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      idx = bit_index(i);
      spi_bit(mw[idx], ack_last && (i == nbits - 1), b);
      mi_word[idx] = b;
      if (i == 0) busy_mid = busy;
    end
    wait_clk(6);
    ss_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic ack_word();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] mi_word;
    logic        busy_mid;
    logic        b;
    int          ovr0;
    int          udr0;

    reset_n = 1'b0;
    sclk    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    rx_ack  = 1'b0;
    wait_clk(3);
    check_output("reset_miso",     32'(miso), 32'h0);
    check_output("reset_rx_data",  rx_data, 32'h0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'h0);
    check_output("reset_busy",     32'(busy), 32'h0);
    check_output("reset_flags",    {30'h0, rx_overrun, tx_underrun}, 32'h0);
    reset_n = 1'b1;
    wait_clk(4);

    $display("[TB] basic frame");
    ovr0 = ovr_cnt; udr0 = udr_cnt;
    load_word(32'hA5A5_0F0F);
    apply_stimulus(32'h1234_5678, 32, 1'b0, mi_word, busy_mid);
    check_output("basic_miso",     mi_word, 32'hA5A5_0F0F);
    check_output("basic_rx_data",  rx_data, 32'h1234_5678);
    check_output("basic_rx_valid", 32'(rx_valid), 32'h1);
    check_output("basic_busy_mid", 32'(busy_mid), 32'h1);
    check_output("basic_busy_end", 32'(busy), 32'h0);
    check_output("basic_overrun",  32'(ovr_cnt - ovr0), 32'h0);
    check_output("basic_underrun", 32'(udr_cnt - udr0), 32'h0);
    ack_word();
    check_output("ack_clears_valid", 32'(rx_valid), 32'h0);

    $display("[TB] back-to-back frames, no ack");
    ovr0 = ovr_cnt;
    load_word(32'h1111_2222);
    apply_stimulus(32'h0000_0001, 32, 1'b0, mi_word, busy_mid);
    check_output("b2b_first_overrun", 32'(ovr_cnt - ovr0), 32'h0);
    load_word(32'h3333_4444);
    apply_stimulus(32'h0000_0002, 32, 1'b0, mi_word, busy_mid);
    check_output("b2b_overrun",  32'(ovr_cnt - ovr0), 32'h1);
    check_output("b2b_rx_data",  rx_data, 32'h0000_0002);
    check_output("b2b_miso",     mi_word, 32'h3333_4444);
    ack_word();

    $display("[TB] frame without tx_load");
    ovr0 = ovr_cnt; udr0 = udr_cnt;
    apply_stimulus(32'h0000_0055, 32, 1'b0, mi_word, busy_mid);
    check_output("udr_pulse",   32'(udr_cnt - udr0), 32'h1);
    check_output("udr_miso",    mi_word, 32'h0000_0000);
    check_output("udr_rx_data", rx_data, 32'h0000_0055);
    check_output("udr_overrun", 32'(ovr_cnt - ovr0), 32'h0);

    $display("[TB] abort after 17 bits");
    load_word(32'h8765_4321);
    apply_stimulus(32'hFFFF_FFFF, 17, 1'b0, mi_word, busy_mid);
    check_output("abort_busy",     32'(busy), 32'h0);
    check_output("abort_rx_valid", 32'(rx_valid), 32'h1);
    check_output("abort_rx_data",  rx_data, 32'h0000_0055);
    ack_word();
    ovr0 = ovr_cnt;
    load_word(32'h0BAD_F00D);
    apply_stimulus(32'hDEAD_BEEF, 32, 1'b0, mi_word, busy_mid);
    check_output("post_abort_rx_data",  rx_data, 32'hDEAD_BEEF);
    check_output("post_abort_rx_valid", 32'(rx_valid), 32'h1);
    check_output("post_abort_miso",     mi_word, 32'h0BAD_F00D);
    check_output("post_abort_overrun",  32'(ovr_cnt - ovr0), 32'h0);

    $display("[TB] ack coincident with completion");
    ovr0 = ovr_cnt;
    load_word(32'h5A5A_5A5A);
    apply_stimulus(32'hCAFE_F00D, 32, 1'b1, mi_word, busy_mid);
    check_output("coinc_rx_valid", 32'(rx_valid), 32'h1);
    check_output("coinc_rx_data",  rx_data, 32'hCAFE_F00D);
    check_output("coinc_overrun",  32'(ovr_cnt - ovr0), 32'h0);

    $display("[TB] reset mid-frame");
    load_word(32'hFFFF_FFFF);
    ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, b);
    wait_clk(2);
    check_output("pre_reset_miso", 32'(miso), 32'h1);
    check_output("pre_reset_busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_miso",     32'(miso), 32'h0);
    check_output("midrst_rx_data",  rx_data, 32'h0);
    check_output("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("midrst_busy",     32'(busy), 32'h0);
    check_output("midrst_flags",    {30'h0, rx_overrun, tx_underrun}, 32'h0);
    ss_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);

    udr0 = udr_cnt;
    apply_stimulus(32'h0000_00A0, 32, 1'b0, mi_word, busy_mid);
    check_output("postrst_underrun", 32'(udr_cnt - udr0), 32'h1);
    check_output("postrst_hold_zero", mi_word, 32'h0);
    ack_word();
    load_word(32'h0F0F_1234);
    apply_stimulus(32'h1357_9BDF, 32, 1'b0, mi_word, busy_mid);
    check_output("postrst_rx_data",  rx_data, 32'h1357_9BDF);
    check_output("postrst_rx_valid", 32'(rx_valid), 32'h1);
    check_output("postrst_miso",     mi_word, 32'h0F0F_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
